// File: rtl/operand_stack.sv
// LIFO operand stack with registered read port and combinational occupancy flags.
// Define OPERAND_STACK_ERR_EN to enable the sticky overflow/underflow flag on err.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       tos,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       stack_empty,
    output logic                       stack_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_next;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             do_write;
    logic             load_dout;
    logic             overflow;
    logic             underflow;

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == CW'(DEPTH));
    assign count       = sp;
    // Truncation makes sp == DEPTH map to the last slot, which is the top when full.
    assign top_idx     = sp[AW-1:0] - AW'(1);

    always_comb begin
        sp_next   = sp;
        wr_idx    = sp[AW-1:0];
        do_write  = 1'b0;
        load_dout = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (push && pop && !stack_empty) begin
            // Replace-top: read the old value out while overwriting the same slot.
            do_write  = 1'b1;
            wr_idx    = top_idx;
            load_dout = 1'b1;
        end else if (push) begin
            if (stack_full) begin
                overflow = 1'b1;
            end else begin
                do_write  = 1'b1;
                sp_next   = sp + CW'(1);
                load_dout = tos && !stack_empty;
            end
        end else if (pop || tos) begin
            if (stack_empty) begin
                underflow = 1'b1;
            end else begin
                load_dout = 1'b1;
                if (pop) begin
                    sp_next = sp - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp   <= '0;
            dout <= '0;
        end else begin
            sp <= sp_next;
            if (load_dout) begin
                dout <= mem[top_idx];
            end
        end
    end

    // Storage is deliberately left out of reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_idx] <= din;
        end
    end

`ifdef OPERAND_STACK_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (overflow || underflow) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_events;
    assign unused_events = overflow | underflow;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_operand_stack.sv
// Directed and randomized self-checking bench for operand_stack (WIDTH=8, DEPTH=16).
module tb_operand_stack;

`ifdef OPERAND_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       tos = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       stack_empty;
    logic       stack_full;
    logic [4:0] count;
    logic       err;

    int tests_run = 0;
    int fail_count = 0;

    operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .tos(tos),
        .din(din),
        .dout(dout),
        .stack_empty(stack_empty),
        .stack_full(stack_full),
        .count(count),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic p, input logic po, input logic t, input logic [7:0] d);
        push = p;
        pop  = po;
        tos  = t;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (count !== 5'd0) begin fail_count++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        tests_run++;
        if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_flags: got empty=%b full=%b expected empty=1 full=0", stack_empty, stack_full); end
        tests_run++;
        if (dout !== 8'h00) begin fail_count++; $display("[TB] FAIL reset_dout: got %h expected 00", dout); end
        tests_run++;
        if (err !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_push_pop();
        do_reset();
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        tests_run++;
        if (count !== 5'd3 || stack_empty !== 1'b0) begin fail_count++; $display("[TB] FAIL push3: got count=%0d empty=%b expected count=3 empty=0", count, stack_empty); end
        tests_run++;
        if (dout !== 8'h00) begin fail_count++; $display("[TB] FAIL push_dout_hold: got %h expected 00", dout); end
        step(0, 1, 0, 8'h00);
        tests_run++;
        if (dout !== 8'h33 || count !== 5'd2) begin fail_count++; $display("[TB] FAIL pop_top: got dout=%h count=%0d expected dout=33 count=2", dout, count); end
        step(0, 0, 0, 8'hEE);
        tests_run++;
        if (dout !== 8'h33 || count !== 5'd2) begin fail_count++; $display("[TB] FAIL idle_hold: got dout=%h count=%0d expected dout=33 count=2", dout, count); end
    endtask

    // Continues from the [11,22] stack left by test_push_pop.
    task automatic test_tos_replace();
        step(0, 0, 1, 8'h00);
        tests_run++;
        if (dout !== 8'h22 || count !== 5'd2) begin fail_count++; $display("[TB] FAIL tos_peek: got dout=%h count=%0d expected dout=22 count=2", dout, count); end
        step(1, 1, 0, 8'h5A);
        tests_run++;
        if (dout !== 8'h22 || count !== 5'd2) begin fail_count++; $display("[TB] FAIL replace_top: got dout=%h count=%0d expected dout=22 count=2", dout, count); end
        step(0, 0, 1, 8'h00);
        tests_run++;
        if (dout !== 8'h5A) begin fail_count++; $display("[TB] FAIL replace_tos: got %h expected 5a", dout); end
        step(0, 1, 1, 8'h00);
        tests_run++;
        if (dout !== 8'h5A || count !== 5'd1) begin fail_count++; $display("[TB] FAIL pop_tos: got dout=%h count=%0d expected dout=5a count=1", dout, count); end
        step(1, 0, 1, 8'h77);
        tests_run++;
        if (dout !== 8'h11 || count !== 5'd2) begin fail_count++; $display("[TB] FAIL push_tos: got dout=%h count=%0d expected dout=11 count=2", dout, count); end
        step(0, 1, 0, 8'h00);
        tests_run++;
        if (dout !== 8'h77 || count !== 5'd1) begin fail_count++; $display("[TB] FAIL push_tos_pop: got dout=%h count=%0d expected dout=77 count=1", dout, count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 8'(i));
        end
        tests_run++;
        if (stack_full !== 1'b1 || count !== 5'd16) begin fail_count++; $display("[TB] FAIL fill: got full=%b count=%0d expected full=1 count=16", stack_full, count); end
        step(1, 0, 0, 8'hFF);
        tests_run++;
        if (count !== 5'd16 || dout !== 8'h00) begin fail_count++; $display("[TB] FAIL overflow_ignored: got count=%0d dout=%h expected count=16 dout=00", count, dout); end
        tests_run++;
        if (err !== ERR_EN) begin fail_count++; $display("[TB] FAIL overflow_err: got %b expected %b", err, ERR_EN); end
        step(1, 0, 1, 8'hFE);
        tests_run++;
        if (count !== 5'd16 || dout !== 8'h00) begin fail_count++; $display("[TB] FAIL overflow_tos_ignored: got count=%0d dout=%h expected count=16 dout=00", count, dout); end
        step(0, 1, 0, 8'h00);
        tests_run++;
        if (dout !== 8'h0F || count !== 5'd15 || stack_full !== 1'b0) begin fail_count++; $display("[TB] FAIL pop_after_full: got dout=%h count=%0d full=%b expected dout=0f count=15 full=0", dout, count, stack_full); end
        tests_run++;
        if (err !== ERR_EN) begin fail_count++; $display("[TB] FAIL err_sticky: got %b expected %b", err, ERR_EN); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1, 0, 0, 8'h99);
        step(0, 1, 0, 8'h00);
        tests_run++;
        if (dout !== 8'h99 || stack_empty !== 1'b1 || err !== 1'b0) begin fail_count++; $display("[TB] FAIL drain: got dout=%h empty=%b err=%b expected dout=99 empty=1 err=0", dout, stack_empty, err); end
        step(1, 1, 0, 8'hAB);
        tests_run++;
        if (count !== 5'd1 || dout !== 8'h99 || err !== 1'b0) begin fail_count++; $display("[TB] FAIL push_pop_empty: got count=%0d dout=%h err=%b expected count=1 dout=99 err=0", count, dout, err); end
        step(0, 1, 0, 8'h00);
        tests_run++;
        if (dout !== 8'hAB || count !== 5'd0) begin fail_count++; $display("[TB] FAIL push_pop_empty_pop: got dout=%h count=%0d expected dout=ab count=0", dout, count); end
        step(0, 1, 0, 8'h00);
        tests_run++;
        if (count !== 5'd0 || dout !== 8'hAB) begin fail_count++; $display("[TB] FAIL underflow_ignored: got count=%0d dout=%h expected count=0 dout=ab", count, dout); end
        tests_run++;
        if (err !== ERR_EN) begin fail_count++; $display("[TB] FAIL underflow_err: got %b expected %b", err, ERR_EN); end
    endtask

    task automatic test_tos_underflow();
        do_reset();
        step(0, 0, 1, 8'h00);
        tests_run++;
        if (count !== 5'd0 || dout !== 8'h00 || err !== ERR_EN) begin fail_count++; $display("[TB] FAIL tos_empty: got count=%0d dout=%h err=%b expected count=0 dout=00 err=%b", count, dout, err, ERR_EN); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 0, 0, 8'h44);
        step(0, 0, 1, 8'h00);
        rst = 1'b1;
        step(1, 0, 0, 8'h55);
        rst = 1'b0;
        tests_run++;
        if (count !== 5'd0 || dout !== 8'h00 || err !== 1'b0 || stack_empty !== 1'b1) begin fail_count++; $display("[TB] FAIL reset_mid: got count=%0d dout=%h err=%b empty=%b expected 0/00/0/1", count, dout, err, stack_empty); end
        step(1, 0, 0, 8'h66);
        step(0, 1, 0, 8'h00);
        tests_run++;
        if (dout !== 8'h66 || count !== 5'd0) begin fail_count++; $display("[TB] FAIL reset_mid_reuse: got dout=%h count=%0d expected dout=66 count=0", dout, count); end
    endtask

    task automatic test_random();
        logic [7:0] model_q[$];
        logic [7:0] exp_dout;
        logic       exp_err;
        logic       p, po, t;
        logic [7:0] d;
        int         push_pct;
        do_reset();
        exp_dout = 8'h00;
        exp_err  = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            push_pct = ((cyc / 250) % 2 == 0) ? 75 : 25;
            p  = ($urandom_range(0, 99) < push_pct);
            po = ($urandom_range(0, 99) < (100 - push_pct));
            t  = ($urandom_range(0, 99) < 30);
            d  = 8'($urandom);
            if (p && po && model_q.size() > 0) begin
                exp_dout = model_q[$];
                model_q[$] = d;
            end else if (p) begin
                if (model_q.size() == 16) begin
                    exp_err = ERR_EN;
                end else begin
                    if (t && model_q.size() > 0) exp_dout = model_q[$];
                    model_q.push_back(d);
                end
            end else if (po || t) begin
                if (model_q.size() == 0) begin
                    exp_err = ERR_EN;
                end else begin
                    exp_dout = model_q[$];
                    if (po) void'(model_q.pop_back());
                end
            end
            step(p, po, t, d);
            tests_run++;
            if (dout !== exp_dout || count !== 5'(model_q.size()) ||
                stack_empty !== (model_q.size() == 0) || stack_full !== (model_q.size() == 16) || err !== exp_err) begin
                fail_count++;
                $display("[TB] FAIL random_c%0d: got dout=%h count=%0d empty=%b full=%b err=%b expected dout=%h count=%0d err=%b",
                         cyc, dout, count, stack_empty, stack_full, err, exp_dout, model_q.size(), exp_err);
            end
        end
        step(0, 0, 0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_tos_replace();
        test_full();
        test_underflow();
        test_tos_underflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 push  input  1  write din onto the top of the stack.
REQ-006 pop  input  1  remove the top entry and return it on dout.
REQ-007 tos  input  1  return the top entry on dout without removing it.
REQ-008 din  input  WIDTH  data to push.
REQ-009 dout  output  WIDTH  registered read data.
REQ-010 stack_empty  output  1  high when the entry count is 0.
REQ-011 stack_full  output  1  high when the entry count equals DEPTH.
REQ-012 count  output  clog2(DEPTH)+1  current number of entries.
REQ-013 err  output  1  sticky overflow/underflow flag.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH register array; the pointer sp SHALL equal count, and the top entry SHALL be mem[sp-1].
REQ-015 Push alone, not full: at the edge, mem[sp] <= din and sp <= sp+1; dout unchanged.
REQ-016 Pop alone, not empty: at the edge, dout <= mem[sp-1] and sp <= sp-1; read latency 1 cycle.
REQ-017 Tos alone, not empty: at the edge, dout <= mem[sp-1]; sp and mem unchanged.
REQ-018 Pop and tos together SHALL behave as pop alone.
REQ-019 Push and pop together, not empty: dout <= old top, mem[sp-1] <= din, sp unchanged (replace top).
REQ-020 Push and pop together when empty: treated as push alone; dout unchanged; no underflow.
REQ-021 Push and tos together, not empty: push performed; dout <= the pre-push top.
REQ-022 Push when full, no pop: ignored; mem, sp and dout unchanged; overflow event.
REQ-023 Pop or tos when empty, no push: ignored; sp and dout unchanged; underflow event.
REQ-024 stack_empty, stack_full and count SHALL be combinational decodes of sp, valid in the same cycle sp changes.
REQ-025 sp SHALL never wrap: it stays within 0..DEPTH under all input combinations.
REQ-026 With no command asserted, all state SHALL hold.

Reset
REQ-027 With rst high at an edge: sp <= 0, dout <= 0, err <= 0; rst overrides every command in that cycle.
REQ-028 Array contents are not reset; after reset they are unobservable until rewritten.
REQ-029 Reset mid-sequence SHALL discard all entries; stack_empty=1 in the cycle after the reset edge.

Configuration
REQ-030 Macro OPERAND_STACK_ERR_EN: when defined, err is set on any overflow or underflow event and holds until reset.
REQ-031 When OPERAND_STACK_ERR_EN is undefined, err SHALL be constant 0; the ignore behaviour in REQ-022/023 is unchanged.

Verification
REQ-032 Reset, then push 0x11, 0x22, 0x33 -> count=3, stack_empty=0; pop -> dout=0x33 one cycle later, count=2.
REQ-033 Tos with top 0x22 -> dout=0x22, count stays 2; then push+pop with din=0x5A -> dout=0x22, count=2, next tos -> 0x5A.
REQ-034 Push 16 values 0x00..0x0F -> stack_full=1; 17th push 0xFF -> count=16, err=1 (with macro), next pop -> 0x0F.
REQ-035 Pop on empty stack -> count=0, dout unchanged, err=1 with macro, err=0 without.
REQ-036 Push 0x44, then rst high with push=1 -> count=0, dout=0, err=0, stack_empty=1.
REQ-037 Random push/pop/tos mix for 2000 cycles against a queue model -> dout, count and flags match every cycle.
